// File: rtl/reset_pkg.sv
// reset_pkg: shared state/cause encodings and counter sizing helper for reset_sequencer
package reset_pkg;
    typedef enum logic [2:0] {WAIT_LOCK, DELAY, ASSERT, RELEASE, RUN} state_t;
    typedef enum logic [1:0] {CAUSE_POR = 2'd0, CAUSE_SW = 2'd1, CAUSE_LOCK = 2'd2} cause_t;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: 2-FF async-assert / sync-deassert reset synchroniser
//   clk          in   clock
//   rst_n_i      in   raw active-low reset
//   rst_sync_n_o out  synchronised active-low reset, high on the 2nd edge after release
module reset_sync (
    input  logic clk,
    input  logic rst_n_i,
    output logic rst_sync_n_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= '0;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_sync_n_o = sync_q[1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-gated, staggered multi-domain reset generator with cause capture
//   clk         in   system clock
//   rst_n       in   async active-low board reset
//   pll_locked  in   PLL lock, asynchronous to clk
//   sw_rst_req  in   1-cycle software reset request
//   rst_out     out  per-domain active-high resets, channel 0 released first
//   done        out  all channels released
//   rst_cause   out  cause of last sequence (POR / SW / LOCK_LOSS)
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int DELAY_CYCLES   = 100,
    parameter int PULSE_CYCLES   = 100,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              done,
    output logic [1:0]        rst_cause
);
    localparam int CNT_W = $clog2(max3(DELAY_CYCLES, PULSE_CYCLES, (NUM_CH - 1) * STAGGER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLS_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic              rst_sync_n;
    logic [1:0]        lock_q;
    logic              lock_s;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [NUM_CH-1:0] rst_out_q;
    logic [NUM_CH-1:0] clr;
    logic              done_q;
    cause_t            cause_q;

    reset_sync u_rst_sync (
        .clk          (clk),
        .rst_n_i      (rst_n),
        .rst_sync_n_o (rst_sync_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= '0;
        else        lock_q <= {lock_q[0], pll_locked};
    end
    assign lock_s = lock_q[1];

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Channel 0 drops on the edge entering RELEASE; channel i drops when the counter reaches i*STAGGER.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_clr
        if (i == 0) begin : g_first
            assign clr[i] = (state_q == ASSERT) && (cnt_q == PLS_LAST);
        end else begin : g_rest
            assign clr[i] = (state_q == RELEASE) && (cnt_inc == CNT_W'(i * STAGGER_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_POR;
        end else if (!lock_s && state_q != WAIT_LOCK) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (rst_sync_n && lock_s) begin
                        state_q <= DELAY;
                        cnt_q   <= '0;
                    end
                end
                DELAY: begin
                    state_q <= (cnt_q == DLY_LAST) ? ASSERT : DELAY;
                    cnt_q   <= (cnt_q == DLY_LAST) ? '0 : cnt_inc;
                end
                ASSERT: begin
                    state_q   <= (cnt_q == PLS_LAST) ? RELEASE : ASSERT;
                    cnt_q     <= (cnt_q == PLS_LAST) ? '0 : cnt_inc;
                    rst_out_q <= rst_out_q & ~clr;
                end
                RELEASE: begin
                    // Leave one edge after the last channel dropped so done lands right after it.
                    if (!rst_out_q[NUM_CH-1]) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_inc;
                        rst_out_q <= rst_out_q & ~clr;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        state_q   <= ASSERT;
                        cnt_q     <= '0;
                        rst_out_q <= '1;
                        done_q    <= 1'b0;
                        cause_q   <= CAUSE_SW;
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign rst_out   = rst_out_q;
    assign done      = done_q;
    assign rst_cause = cause_q;
endmodule
